exmem_latch: RTL and testbench
==============================

Name: exmem_latch

Overview:
- EX/MEM pipeline register, directly downstream of the ID/EX register and the execute stage.
- Captures ALU result, store data, destination register and memory/writeback control from EX.
- Holds the data-cache request stable until it is serviced.
- Supports stall, flush (bubble insertion), a sticky halt, and a retired-instruction counter for debug.

Parameters:
- CNT_W, 32, width of the valid-capture counter cnt_out; wraps modulo 2^CNT_W.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- ihit  input  1  pipeline advance request for this cycle.
- dhit  input  1  data cache has serviced the outstanding dREN_out/dWEN_out request this cycle.
- flush  input  1  replace the latch contents with a bubble at the next edge.
- valid_in  input  1  EX stage holds a real instruction.
- regWEN_in  input  1  register write enable.
- memOp_in  input  2  writeback source select: 0 = ALU, 1 = memory, 2 = pc+4, 3 = lui.
- dREN_in  input  1  load request.
- dWEN_in  input  1  store request.
- halt_in  input  1  halt instruction.
- wsel_in  input  5  destination register.
- aluout_in  input  32  ALU result / memory address.
- rdat2_in  input  32  store data.
- pc_in  input  32  instruction pc.
- imm_in  input  16  immediate, used for lui.
- Outputs with the same name, suffix _out and width: valid_out, regWEN_out, memOp_out, dREN_out, dWEN_out, halt_out, wsel_out, aluout_out, rdat2_out, pc_out, imm_out.
- mem_busy  output  1  combinational: dREN_out | dWEN_out.
- cnt_out  output  CNT_W  number of valid instructions captured since reset.

Behaviour:
- Reset: on RST high, asynchronously, every registered output is 0 (valid_out, regWEN_out, memOp_out, dREN_out, dWEN_out, halt_out, wsel_out, aluout_out, rdat2_out, pc_out, imm_out, cnt_out). mem_busy is therefore 0. Reset mid-request drops the request; no cleanup cycle.
- advance = ihit & ~halt_out & (~mem_busy | dhit).
- Next-state selection each rising edge, first match wins:
  1. halt_out = 1: freeze all fields; dhit still clears dREN_out/dWEN_out. flush is ignored.
  2. flush = 1: bubble. valid_out, regWEN_out, dREN_out, dWEN_out and halt_out are 0; memOp_out, wsel_out and all data fields are 0; cnt_out holds. flush overrides advance.
  3. advance = 1: capture every *_in to *_out. cnt_out increments by 1 iff valid_in = 1.
  4. dhit = 1 (no advance): clear dREN_out and dWEN_out only; every other field holds.
  5. Otherwise: hold all fields.
- Handshake: once dREN_out or dWEN_out is 1, it stays 1 until a cycle with dhit = 1.
  - ihit without dhit while busy does not advance; the latch holds.
  - dhit together with ihit in the same cycle advances: the new instruction's requests replace the old ones.
- halt_out is sticky: it becomes 1 only by capturing halt_in = 1 and is cleared only by RST.
- Latency: exactly one cycle from *_in to *_out on an advancing edge.
- cnt_out wraps from 2^CNT_W-1 to 0 with no flag.
- Each bubble, capture or dHit clear takes effect only at the rising edge; outputs are glitch-free registers, except mem_busy.

Test Plan:
1. Reset then single capture: RST pulse; then ihit=1, valid_in=1, aluout_in=0x0000_00F0, wsel_in=5'd9, regWEN_in=1, memOp_in=0 -> after one edge aluout_out=0xF0, wsel_out=9, regWEN_out=1, valid_out=1, cnt_out=1.
2. Load handshake: capture dREN_in=1, aluout_in=0x100. Next 2 cycles ihit=1, dhit=0 -> outputs frozen, mem_busy=1. Cycle 3: dhit=1, ihit=0 -> dREN_out=0, aluout_out still 0x100. Cycle 4: ihit=1 -> new capture.
3. Simultaneous dhit and ihit with dWEN_out=1, new input aluout_in=0x200, dWEN_in=0 -> one edge later aluout_out=0x200, dWEN_out=0, no hold cycle.
4. Flush priority: ihit=1, flush=1, valid_in=1, regWEN_in=1 -> valid_out=0, regWEN_out=0, aluout_out=0, cnt_out unchanged.
5. Halt sticky: capture halt_in=1; next cycles apply flush=1, ihit=1, halt_in=0 -> halt_out stays 1, all fields frozen. RST -> halt_out=0.
6. Counter wrap with CNT_W=4: 16 valid captures -> cnt_out goes 15 then 0. Captures with valid_in=0 -> cnt_out unchanged.

Source files
------------

// File: rtl/exmem_latch_if.sv
// EX/MEM latch bus: EX-side inputs, MEM-side registered outputs and the
// combinational data-cache busy indication.
interface exmem_latch_if;
    // EX-stage inputs
    logic        ihit;
    logic        dhit;
    logic        flush;
    logic        valid_in;
    logic        regWEN_in;
    logic [1:0]  memOp_in;
    logic        dREN_in;
    logic        dWEN_in;
    logic        halt_in;
    logic [4:0]  wsel_in;
    logic [31:0] aluout_in;
    logic [31:0] rdat2_in;
    logic [31:0] pc_in;
    logic [15:0] imm_in;

    // MEM-stage outputs
    logic        valid_out;
    logic        regWEN_out;
    logic [1:0]  memOp_out;
    logic        dREN_out;
    logic        dWEN_out;
    logic        halt_out;
    logic [4:0]  wsel_out;
    logic [31:0] aluout_out;
    logic [31:0] rdat2_out;
    logic [31:0] pc_out;
    logic [15:0] imm_out;
    logic        mem_busy;

    modport master (
        output ihit, dhit, flush, valid_in, regWEN_in, memOp_in, dREN_in,
               dWEN_in, halt_in, wsel_in, aluout_in, rdat2_in, pc_in, imm_in,
        input  valid_out, regWEN_out, memOp_out, dREN_out, dWEN_out,
               halt_out, wsel_out, aluout_out, rdat2_out, pc_out, imm_out,
               mem_busy
    );

    modport slave (
        input  ihit, dhit, flush, valid_in, regWEN_in, memOp_in, dREN_in,
               dWEN_in, halt_in, wsel_in, aluout_in, rdat2_in, pc_in, imm_in,
        output valid_out, regWEN_out, memOp_out, dREN_out, dWEN_out,
               halt_out, wsel_out, aluout_out, rdat2_out, pc_out, imm_out,
               mem_busy
    );
endinterface

// File: rtl/exmem_latch.sv
// EX/MEM pipeline register with stall, flush, dcache request hold,
// sticky halt and a wrapping count of captured valid instructions.
module exmem_latch #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    exmem_latch_if.slave     bus,
    output logic [CNT_W-1:0] cnt_out
);

    typedef struct packed {
        logic        valid;
        logic        reg_wen;
        logic [1:0]  mem_op;
        logic        dren;
        logic        dwen;
        logic        halt;
        logic [4:0]  wsel;
        logic [31:0] aluout;
        logic [31:0] rdat2;
        logic [31:0] pc;
        logic [15:0] imm;
    } stage_t;

    stage_t           stage_q, stage_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_busy;
    logic             advance;

    assign mem_busy = stage_q.dren | stage_q.dwen;
    assign advance  = bus.ihit & ~stage_q.halt & (~mem_busy | bus.dhit);

    // Next-state priority: halt, flush, advance, dhit clear, hold
    always_comb begin
        stage_d = stage_q;
        cnt_d   = cnt_q;
        if (stage_q.halt) begin
            // Halted contents are frozen, but an outstanding request must still retire
            if (bus.dhit) begin
                stage_d.dren = 1'b0;
                stage_d.dwen = 1'b0;
            end
        end else if (bus.flush) begin
            stage_d = '0;
        end else if (advance) begin
            stage_d.valid   = bus.valid_in;
            stage_d.reg_wen = bus.regWEN_in;
            stage_d.mem_op  = bus.memOp_in;
            stage_d.dren    = bus.dREN_in;
            stage_d.dwen    = bus.dWEN_in;
            stage_d.halt    = bus.halt_in;
            stage_d.wsel    = bus.wsel_in;
            stage_d.aluout  = bus.aluout_in;
            stage_d.rdat2   = bus.rdat2_in;
            stage_d.pc      = bus.pc_in;
            stage_d.imm     = bus.imm_in;
            if (bus.valid_in) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (bus.dhit) begin
            stage_d.dren = 1'b0;
            stage_d.dwen = 1'b0;
        end
    end

    // Pipeline register and counter state, asynchronously cleared
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stage_q <= '0;
            cnt_q   <= '0;
        end else begin
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.valid_out  = stage_q.valid;
    assign bus.regWEN_out = stage_q.reg_wen;
    assign bus.memOp_out  = stage_q.mem_op;
    assign bus.dREN_out   = stage_q.dren;
    assign bus.dWEN_out   = stage_q.dwen;
    assign bus.halt_out   = stage_q.halt;
    assign bus.wsel_out   = stage_q.wsel;
    assign bus.aluout_out = stage_q.aluout;
    assign bus.rdat2_out  = stage_q.rdat2;
    assign bus.pc_out     = stage_q.pc;
    assign bus.imm_out    = stage_q.imm;
    assign bus.mem_busy   = mem_busy;
    assign cnt_out        = cnt_q;

endmodule

// File: tb/tb_exmem_latch.sv
// Directed self-checking bench for exmem_latch (CNT_W = 4 to reach the wrap).
module tb_exmem_latch;

    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [CNT_W-1:0] cnt_out;
    int               n_checks;
    int               n_fail;

    exmem_latch_if bus();

    exmem_latch #(.CNT_W(CNT_W)) dut (
        .CLK     (clk),
        .RST     (rst),
        .bus     (bus),
        .cnt_out (cnt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ihit = 0; bus.dhit = 0; bus.flush = 0; bus.valid_in = 0;
        bus.regWEN_in = 0; bus.memOp_in = 0; bus.dREN_in = 0; bus.dWEN_in = 0;
        bus.halt_in = 0; bus.wsel_in = 0; bus.aluout_in = 0; bus.rdat2_in = 0;
        bus.pc_in = 0; bus.imm_in = 0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clear_inputs();
        rst = 1'b1;
        #12;
        chk("rst_valid", 32'(bus.valid_out), 32'd0);
        chk("rst_cnt", 32'(cnt_out), 32'd0);
        chk("rst_busy", 32'(bus.mem_busy), 32'd0);
        chk("rst_halt", 32'(bus.halt_out), 32'd0);
        rst = 1'b0;

        // 1: single capture
        bus.ihit = 1; bus.valid_in = 1; bus.aluout_in = 32'hF0; bus.wsel_in = 5'd9;
        bus.regWEN_in = 1; bus.memOp_in = 2'd0; bus.pc_in = 32'h40; bus.imm_in = 16'h1234;
        step();
        chk("cap_alu", bus.aluout_out, 32'hF0);
        chk("cap_wsel", 32'(bus.wsel_out), 32'd9);
        chk("cap_regwen", 32'(bus.regWEN_out), 32'd1);
        chk("cap_valid", 32'(bus.valid_out), 32'd1);
        chk("cap_cnt", 32'(cnt_out), 32'd1);
        chk("cap_imm", 32'(bus.imm_out), 32'h1234);

        // 2: load handshake
        bus.dREN_in = 1; bus.aluout_in = 32'h100; bus.memOp_in = 2'd1; bus.wsel_in = 5'd3;
        step();
        chk("ld_dren", 32'(bus.dREN_out), 32'd1);
        chk("ld_memop", 32'(bus.memOp_out), 32'd1);
        chk("ld_cnt", 32'(cnt_out), 32'd2);
        bus.dREN_in = 0; bus.aluout_in = 32'h555; bus.wsel_in = 5'd7;
        step();
        chk("stall1_alu", bus.aluout_out, 32'h100);
        chk("stall1_busy", 32'(bus.mem_busy), 32'd1);
        step();
        chk("stall2_alu", bus.aluout_out, 32'h100);
        chk("stall2_wsel", 32'(bus.wsel_out), 32'd3);
        chk("stall2_cnt", 32'(cnt_out), 32'd2);
        bus.ihit = 0; bus.dhit = 1;
        step();
        chk("dhit_dren", 32'(bus.dREN_out), 32'd0);
        chk("dhit_alu", bus.aluout_out, 32'h100);
        chk("dhit_busy", 32'(bus.mem_busy), 32'd0);
        bus.ihit = 1; bus.dhit = 0;
        step();
        chk("next_alu", bus.aluout_out, 32'h555);
        chk("next_cnt", 32'(cnt_out), 32'd3);

        // 3: simultaneous dhit and ihit on a store
        bus.dWEN_in = 1; bus.aluout_in = 32'h300; bus.rdat2_in = 32'hDEAD;
        step();
        chk("st_dwen", 32'(bus.dWEN_out), 32'd1);
        chk("st_rdat2", bus.rdat2_out, 32'hDEAD);
        bus.dhit = 1; bus.dWEN_in = 0; bus.aluout_in = 32'h200;
        step();
        chk("sim_alu", bus.aluout_out, 32'h200);
        chk("sim_dwen", 32'(bus.dWEN_out), 32'd0);
        chk("sim_cnt", 32'(cnt_out), 32'd5);
        bus.dhit = 0;

        // 4: flush beats advance
        bus.flush = 1; bus.aluout_in = 32'h777;
        step();
        chk("fl_valid", 32'(bus.valid_out), 32'd0);
        chk("fl_regwen", 32'(bus.regWEN_out), 32'd0);
        chk("fl_alu", bus.aluout_out, 32'h0);
        chk("fl_pc", bus.pc_out, 32'h0);
        chk("fl_cnt", 32'(cnt_out), 32'd5);
        bus.flush = 0;

        // 6: counter wrap after an asynchronous reset between edges
        rst = 1'b1;
        #1;
        chk("arst_cnt", 32'(cnt_out), 32'd0);
        chk("arst_alu", bus.aluout_out, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) step();
        chk("wrap_15", 32'(cnt_out), 32'd15);
        step();
        chk("wrap_0", 32'(cnt_out), 32'd0);
        bus.valid_in = 0;
        step();
        step();
        chk("novalid_cnt", 32'(cnt_out), 32'd0);
        chk("novalid_out", 32'(bus.valid_out), 32'd0);

        // 5: sticky halt
        bus.valid_in = 1; bus.halt_in = 1; bus.dREN_in = 1; bus.aluout_in = 32'hABC;
        step();
        chk("halt_set", 32'(bus.halt_out), 32'd1);
        chk("halt_cnt", 32'(cnt_out), 32'd1);
        bus.flush = 1; bus.halt_in = 0; bus.dREN_in = 0; bus.aluout_in = 32'h999;
        step();
        chk("halt_hold", 32'(bus.halt_out), 32'd1);
        chk("halt_alu", bus.aluout_out, 32'hABC);
        chk("halt_valid", 32'(bus.valid_out), 32'd1);
        chk("halt_dren", 32'(bus.dREN_out), 32'd1);
        bus.dhit = 1;
        step();
        chk("halt_dhit_dren", 32'(bus.dREN_out), 32'd0);
        chk("halt_dhit_alu", bus.aluout_out, 32'hABC);
        chk("halt_dhit_cnt", 32'(cnt_out), 32'd1);
        chk("halt_still", 32'(bus.halt_out), 32'd1);
        rst = 1'b1;
        #1;
        chk("halt_rst", 32'(bus.halt_out), 32'd0);
        chk("halt_rst_alu", bus.aluout_out, 32'h0);
        rst = 1'b0;
        clear_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
